// File: rtl/cpu_core.sv
// 16-bit multi-cycle core: 16x16 register file, {Z,C,F,L,N} PSR,
// shared synchronous 1024x16 memory for instructions and data.
module cpu_core #(
  parameter int overrideRAM = 0
) (
  input  logic        clk,
  input  logic        reset,
  output logic [4:0]  flagLEDs,
  output logic [15:0] r1,
  output logic        write_en,
  output logic [9:0]  addr,
  input  logic [15:0] data_out,
  output logic [15:0] data_in
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB
  } state_t;

  localparam int PZ = 4;
  localparam int PC = 3;
  localparam int PF = 2;
  localparam int PL = 1;
  localparam int PN = 0;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_rf [16];
  logic [15:0] r_pc;
  logic [15:0] r_ir;
  logic [4:0]  r_psr;

  logic [15:0] w_rdata;
  logic [15:0] w_ram_q;

  logic [3:0]  w_op;
  logic [3:0]  w_rd;
  logic [3:0]  w_ext;
  logic [3:0]  w_rs;
  logic [7:0]  w_imm;
  logic [15:0] w_a;
  logic [15:0] w_b;
  logic [15:0] w_simm;
  logic [15:0] w_zimm;

  logic        w_is_r;
  logic        w_is_i;
  logic [3:0]  w_code;
  logic [15:0] w_src;
  logic        w_cin;
  logic [16:0] w_sum;
  logic [16:0] w_dif;
  logic        w_vadd;
  logic        w_vsub;
  logic [15:0] w_namt;
  logic [15:0] w_lsh;
  logic        w_take;
  logic        w_is_mem_d;
  logic        w_is_stor;

  logic        w_wb_en;
  logic [15:0] w_wb_val;
  logic [4:0]  w_psr_n;
  logic [15:0] w_pc_n;

  function automatic logic f_cond(
    input logic [3:0] c,
    input logic [4:0] p
  );
    logic z, cy, f, l, n;
    {z, cy, f, l, n} = p;
    case (c)
      4'h0:    return z;
      4'h1:    return !z;
      4'h2:    return cy;
      4'h3:    return !cy;
      4'h4:    return l;
      4'h5:    return !l;
      4'h6:    return n;
      4'h7:    return !n;
      4'h8:    return f;
      4'h9:    return !f;
      4'hA:    return !l && !z;
      4'hB:    return l || z;
      4'hC:    return !n && !z;
      4'hD:    return n || z;
      4'hE:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Internal RAM has the same one-cycle read latency as the external port
  generate
    if (overrideRAM == 0) begin : g_ram
      logic [15:0] r_mem [1024];
      logic [15:0] r_q;
      always_ff @(posedge clk) begin
        if (write_en) r_mem[addr] <= data_in;
        r_q <= r_mem[addr];
      end
      assign w_ram_q = r_q;
    end else begin : g_noram
      assign w_ram_q = 16'h0000;
    end
  endgenerate

  assign w_rdata = (overrideRAM != 0) ? data_out : w_ram_q;

  assign w_op   = r_ir[15:12];
  assign w_rd   = r_ir[11:8];
  assign w_ext  = r_ir[7:4];
  assign w_rs   = r_ir[3:0];
  assign w_imm  = r_ir[7:0];
  assign w_a    = r_rf[w_rd];
  assign w_b    = r_rf[w_rs];
  assign w_simm = {{8{w_imm[7]}}, w_imm};
  assign w_zimm = {8'h00, w_imm};

  assign w_is_r = (w_op == 4'h0);
  assign w_is_i = w_op inside {4'h1, 4'h2, 4'h3, 4'h5,
                               4'h6, 4'h7, 4'h9, 4'hB, 4'hD};
  assign w_code = w_is_r ? w_ext : w_op;
  assign w_src  = w_is_r ? w_b :
                  (w_op inside {4'h5, 4'h6, 4'h7, 4'h9, 4'hB})
                  ? w_simm : w_zimm;

  assign w_cin  = (w_code == 4'h7) && r_psr[PC];
  assign w_sum  = {1'b0, w_a} + {1'b0, w_src} + {16'h0000, w_cin};
  assign w_dif  = {1'b0, w_a} - {1'b0, w_src};
  assign w_vadd = (w_a[15] == w_src[15]) && (w_sum[15] != w_a[15]);
  assign w_vsub = (w_a[15] != w_src[15]) && (w_dif[15] != w_a[15]);

  assign w_namt = 16'h0000 - w_b;
  assign w_lsh  = w_b[15] ? (w_a >> w_namt) : (w_a << w_b);
  assign w_take = f_cond(w_rd, r_psr);

  assign w_is_mem_d = (w_rdata[15:12] == 4'h4) &&
                      ((w_rdata[7:4] == 4'h0) ||
                       (w_rdata[7:4] == 4'h4));
  assign w_is_stor  = (w_ext == 4'h4);

  always_comb begin
    w_wb_en  = 1'b0;
    w_wb_val = w_a;
    w_psr_n  = r_psr;
    w_pc_n   = r_pc + 16'd1;
    unique case (1'b1)
      (w_is_r || w_is_i): begin
        case (w_code)
          4'h5: begin
            w_wb_en     = 1'b1;
            w_wb_val    = w_sum[15:0];
            w_psr_n[PC] = w_sum[16];
            w_psr_n[PF] = w_vadd;
          end
          4'h6: begin
            w_wb_en     = 1'b1;
            w_wb_val    = w_sum[15:0];
            w_psr_n[PC] = w_sum[16];
          end
          4'h7: begin
            w_wb_en     = 1'b1;
            w_wb_val    = w_sum[15:0];
            w_psr_n[PC] = w_sum[16];
            w_psr_n[PF] = w_vadd;
          end
          4'h9: begin
            w_wb_en     = 1'b1;
            w_wb_val    = w_dif[15:0];
            w_psr_n[PC] = w_dif[16];
            w_psr_n[PF] = w_vsub;
          end
          4'hB: begin
            w_psr_n[PZ] = (w_a == w_src);
            w_psr_n[PL] = (w_a < w_src);
            w_psr_n[PN] = ($signed(w_a) < $signed(w_src));
          end
          4'h1: begin
            w_wb_en  = 1'b1;
            w_wb_val = w_a & w_src;
          end
          4'h2: begin
            w_wb_en  = 1'b1;
            w_wb_val = w_a | w_src;
          end
          4'h3: begin
            w_wb_en  = 1'b1;
            w_wb_val = w_a ^ w_src;
          end
          4'hD: begin
            w_wb_en  = 1'b1;
            w_wb_val = w_src;
          end
          default: ;
        endcase
      end
      (w_op == 4'h8): begin
        case (w_ext)
          4'h4: begin
            w_wb_en  = 1'b1;
            w_wb_val = w_lsh;
          end
          4'h0: begin
            w_wb_en  = 1'b1;
            w_wb_val = w_a << w_rs;
          end
          4'h1: begin
            w_wb_en  = 1'b1;
            w_wb_val = w_a >> w_rs;
          end
          default: ;
        endcase
      end
      (w_op == 4'h4): begin
        if (w_ext == 4'h8) begin
          w_wb_en  = 1'b1;
          w_wb_val = r_pc + 16'd1;
          w_pc_n   = w_b;
        end else if (w_ext == 4'hC && w_take) begin
          w_pc_n = w_b;
        end
      end
      (w_op == 4'hC): begin
        if (w_take) w_pc_n = r_pc + w_simm;
      end
      (w_op == 4'hF): begin
        w_wb_en  = 1'b1;
        w_wb_val = {w_imm, w_a[7:0]};
      end
      default: ;
    endcase
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: w_next = w_is_mem_d ? S_MEM : S_EXEC;
      S_EXEC:   w_next = S_FETCH;
      S_MEM:    w_next = S_WB;
      S_WB:     w_next = S_FETCH;
      default:  w_next = S_FETCH;
    endcase
  end

  // Rsrc of STOR sits in the Rdest field, Raddr in the Rsrc field
  always_comb begin
    addr     = r_pc[9:0];
    write_en = 1'b0;
    data_in  = 16'h0000;
    if (r_state == S_MEM) begin
      addr = w_b[9:0];
      if (w_is_stor) begin
        write_en = 1'b1;
        data_in  = w_a;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_FETCH;
      r_pc    <= 16'h0000;
      r_ir    <= 16'h0000;
      r_psr   <= 5'b00000;
      for (int i = 0; i < 16; i++) r_rf[i] <= 16'h0000;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_ir <= w_rdata;
      if (r_state == S_EXEC) begin
        r_pc  <= w_pc_n;
        r_psr <= w_psr_n;
        if (w_wb_en) r_rf[w_rd] <= w_wb_val;
      end
      if (r_state == S_WB) begin
        r_pc <= r_pc + 16'd1;
        if (!w_is_stor) r_rf[w_rd] <= w_rdata;
      end
    end
  end

  assign r1       = r_rf[1];
  assign flagLEDs = r_psr;

endmodule

// File: tb/tb_cpu_core.sv
// Directed programs for cpu_core run from a bench-side synchronous
// memory on the external port; results checked through r1 and flags.
module tb_cpu_core;

  localparam logic [15:0] HALT = 16'hCE00;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  flagLEDs;
  logic [15:0] r1;
  logic        write_en;
  logic [9:0]  addr;
  logic [15:0] data_out = 16'h0000;
  logic [15:0] data_in;

  logic [15:0] mem [1024];
  logic        ld_en = 1'b0;
  logic [9:0]  ld_addr = 10'd0;
  logic [15:0] ld_data = 16'h0000;
  logic [15:0] prog [$];

  int          we_cnt = 0;
  logic [9:0]  we_addr = 10'd0;
  logic [15:0] we_data = 16'h0000;

  int checks = 0;
  int errors = 0;

  cpu_core #(.overrideRAM(1)) dut (
    .clk      (clk),
    .reset    (reset),
    .flagLEDs (flagLEDs),
    .r1       (r1),
    .write_en (write_en),
    .addr     (addr),
    .data_out (data_out),
    .data_in  (data_in)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (write_en) mem[addr] <= data_in;
    data_out <= mem[addr];
  end

  always @(negedge clk) begin
    if (!reset) begin
      we_cnt <= 0;
    end else if (write_en) begin
      we_cnt  <= we_cnt + 1;
      we_addr <= addr;
      we_data <= data_in;
    end
  end

  task automatic poke(input logic [9:0] a, input logic [15:0] d);
    ld_en   = 1'b1;
    ld_addr = a;
    ld_data = d;
    @(posedge clk);
    #1 ld_en = 1'b0;
  endtask

  task automatic start();
    reset = 1'b0;
    @(negedge clk);
    foreach (prog[i]) poke(10'(i), prog[i]);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    prog = '{16'hD205, 16'h02B2, 16'hD15A, HALT};
    start();
    repeat (20) @(negedge clk);
    checks++;
    if (r1 !== 16'h005A) begin
      errors++;
      $display("FAIL pre_reset_r1: got %h want 005a", r1);
    end
    checks++;
    if (flagLEDs !== 5'b10000) begin
      errors++;
      $display("FAIL pre_reset_flags: got %b want 10000", flagLEDs);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (r1 !== 16'h0000) begin
      errors++;
      $display("FAIL reset_r1: got %h want 0000", r1);
    end
    checks++;
    if (flagLEDs !== 5'b00000) begin
      errors++;
      $display("FAIL reset_flags: got %b want 00000", flagLEDs);
    end
    checks++;
    if (write_en !== 1'b0 || addr !== 10'd0 || data_in !== 16'h0) begin
      errors++;
      $display("FAIL reset_mem_port: got we=%b addr=%h din=%h want 0 0 0",
               write_en, addr, data_in);
    end
    @(negedge clk);
    reset = 1'b1;
    checks++;
    if (addr !== 10'd0) begin
      errors++;
      $display("FAIL first_fetch: got addr %h want 000", addr);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (addr !== 10'd1) begin
      errors++;
      $display("FAIL second_fetch: got addr %h want 001", addr);
    end
  endtask

  task automatic test_fib_add();
    prog = '{16'hD100, 16'hD101, 16'hD201};
    repeat (11) begin
      prog.push_back(16'h03D1);
      prog.push_back(16'h0352);
      prog.push_back(16'h02D1);
      prog.push_back(16'h01D3);
    end
    prog.push_back(HALT);
    start();
    repeat (160) @(negedge clk);
    checks++;
    if (r1 !== 16'd233) begin
      errors++;
      $display("FAIL fib_add: got %0d want 233", r1);
    end
  endtask

  task automatic test_cmp_shift();
    prog = '{16'hD205, 16'h02B2, HALT};
    start();
    repeat (25) @(negedge clk);
    checks++;
    if (flagLEDs !== 5'b10000) begin
      errors++;
      $display("FAIL cmp_eq: got %b want 10000", flagLEDs);
    end
    prog = '{16'hD205, 16'hB203, HALT};
    start();
    repeat (25) @(negedge clk);
    checks++;
    if (flagLEDs !== 5'b00000) begin
      errors++;
      $display("FAIL cmpi_gt: got %b want 00000", flagLEDs);
    end
    prog = '{16'hD101, 16'h8103, HALT};
    start();
    repeat (25) @(negedge clk);
    checks++;
    if (r1 !== 16'd8) begin
      errors++;
      $display("FAIL lshi_left: got %h want 0008", r1);
    end
    prog = '{16'hD201, 16'hB205, HALT};
    start();
    repeat (25) @(negedge clk);
    checks++;
    if (flagLEDs !== 5'b00011) begin
      errors++;
      $display("FAIL cmpi_lt: got %b want 00011", flagLEDs);
    end
    prog = '{16'hD201, 16'hB2FF, HALT};
    start();
    repeat (25) @(negedge clk);
    checks++;
    if (flagLEDs !== 5'b00010) begin
      errors++;
      $display("FAIL cmpi_signed: got %b want 00010", flagLEDs);
    end
    prog = '{16'hD108, 16'hD3FE, 16'hF3FF, 16'h8143, HALT};
    start();
    repeat (25) @(negedge clk);
    checks++;
    if (r1 !== 16'd2 || flagLEDs !== 5'b00000) begin
      errors++;
      $display("FAIL lsh_neg: got r1=%h flags=%b want 0002 00000",
               r1, flagLEDs);
    end
    prog = '{16'hD1F0, 16'h8112, HALT};
    start();
    repeat (25) @(negedge clk);
    checks++;
    if (r1 !== 16'h003C) begin
      errors++;
      $display("FAIL lshi_right: got %h want 003c", r1);
    end
  endtask

  task automatic test_add_flags();
    prog = '{16'hD4FF, 16'hF47F, 16'hD501, 16'h0455, 16'h01D4, HALT};
    start();
    repeat (30) @(negedge clk);
    checks++;
    if (r1 !== 16'h8000 || flagLEDs !== 5'b00100) begin
      errors++;
      $display("FAIL add_ovf: got r1=%h flags=%b want 8000 00100",
               r1, flagLEDs);
    end
    prog = '{16'hD600, 16'h9601, 16'hD501, 16'h0675, 16'h01D6, HALT};
    start();
    repeat (30) @(negedge clk);
    checks++;
    if (r1 !== 16'h0001 || flagLEDs !== 5'b01000) begin
      errors++;
      $display("FAIL sub_addc: got r1=%h flags=%b want 0001 01000",
               r1, flagLEDs);
    end
  endtask

  task automatic test_logic();
    prog = '{16'hD1F0, 16'h210F, 16'h313C, 16'h1181, 16'hF1AB, HALT};
    start();
    repeat (30) @(negedge clk);
    checks++;
    if (r1 !== 16'hAB81 || flagLEDs !== 5'b00000) begin
      errors++;
      $display("FAIL logic_lui: got r1=%h flags=%b want ab81 00000",
               r1, flagLEDs);
    end
  endtask

  task automatic test_mem();
    prog = '{16'hD440, 16'hD564, 16'h4544, 16'hD100, 16'h4104, HALT};
    start();
    repeat (30) @(negedge clk);
    checks++;
    if (r1 !== 16'd100) begin
      errors++;
      $display("FAIL load: got %0d want 100", r1);
    end
    checks++;
    if (we_cnt !== 1) begin
      errors++;
      $display("FAIL stor_we_cycles: got %0d want 1", we_cnt);
    end
    checks++;
    if (we_addr !== 10'h040 || we_data !== 16'd100) begin
      errors++;
      $display("FAIL stor_bus: got addr=%h data=%0d want 040 100",
               we_addr, we_data);
    end
    checks++;
    if (mem[64] !== 16'd100) begin
      errors++;
      $display("FAIL stor_mem: got %0d want 100", mem[64]);
    end
  endtask

  task automatic test_jump();
    prog = '{16'hD13C, 16'hD705, 16'h4887, 16'hD101, 16'hD102,
             16'hD609, 16'h4EC6, 16'hD103, 16'hD104, 16'hCF02, HALT};
    start();
    repeat (50) @(negedge clk);
    checks++;
    if (r1 !== 16'd60) begin
      errors++;
      $display("FAIL jump_skip: got %0d want 60", r1);
    end
    prog = '{16'hD703, 16'h4187, 16'h0000, HALT};
    start();
    repeat (30) @(negedge clk);
    checks++;
    if (r1 !== 16'd2) begin
      errors++;
      $display("FAIL jal_link: got %0d want 2", r1);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    prog = '{16'hD101, 16'hD200, 16'hD40F, 16'h03D1, 16'h0352,
             16'h02D1, 16'h01D3, 16'h9401, 16'hB400, 16'hC1FA, HALT};
    start();
    n = 0;
    while (addr !== 10'd10 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== 324) begin
      errors++;
      $display("FAIL loop_cycles: got %0d want 324", n);
    end
    checks++;
    if (r1 !== 16'd987) begin
      errors++;
      $display("FAIL fib_loop: got %0d want 987", r1);
    end
    checks++;
    if (flagLEDs !== 5'b10000) begin
      errors++;
      $display("FAIL loop_exit_flags: got %b want 10000", flagLEDs);
    end
  endtask

  task automatic test_undef();
    prog = '{16'hD109, 16'hA123, 16'hE1FF, 16'h01F1, 16'h8125,
             16'h4121, HALT};
    start();
    repeat (18) @(negedge clk);
    checks++;
    if (addr !== 10'd6) begin
      errors++;
      $display("FAIL nop_timing: got addr %h want 006", addr);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (r1 !== 16'd9 || flagLEDs !== 5'b00000) begin
      errors++;
      $display("FAIL nop_effect: got r1=%h flags=%b want 0009 00000",
               r1, flagLEDs);
    end
  endtask

  task automatic test_wrap();
    reset = 1'b0;
    poke(10'd1023, 16'h0000);
    prog = '{16'hD7FF, 16'hF703, 16'h5101, 16'hB102, 16'hC002,
             16'h4EC7, HALT};
    start();
    repeat (80) @(negedge clk);
    checks++;
    if (r1 !== 16'd2 || flagLEDs !== 5'b10000) begin
      errors++;
      $display("FAIL pc_wrap: got r1=%h flags=%b want 0002 10000",
               r1, flagLEDs);
    end
  endtask

  task automatic test_reset_abort();
    int n;
    reset = 1'b0;
    poke(10'd64, 16'h0000);
    prog = '{16'hD440, 16'hD507, 16'h4544, HALT};
    start();
    n = 0;
    while (write_en !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (write_en !== 1'b1) begin
      errors++;
      $display("FAIL abort_no_write: got we=%b want 1", write_en);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (write_en !== 1'b0 || addr !== 10'd0 || data_in !== 16'h0) begin
      errors++;
      $display("FAIL abort_port: got we=%b addr=%h din=%h want 0 0 0",
               write_en, addr, data_in);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (mem[64] !== 16'h0000) begin
      errors++;
      $display("FAIL abort_mem: got %h want 0000", mem[64]);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = HALT;
    test_reset();
    test_fib_add();
    test_cmp_shift();
    test_add_flags();
    test_logic();
    test_mem();
    test_jump();
    test_back_to_back();
    test_undef();
    test_wrap();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_core.md
Name: cpu_core

Overview:
- 16-bit multi-cycle CR16-baseline-style processor core: 16×16 register file, 5-bit PSR flags, program counter and ALU.
- Shares one synchronous 1024×16 word-addressed memory for instructions and data.
- Sits at the top of the datapath and drives the board's flag LEDs and a debug view of register r1.
- When overrideRAM=1, memory is external through the addr, write_en, data_in and data_out ports.

Parameters:
- overrideRAM, 0, 1 = use the external memory ports; 0 = instantiate an internal 1024×16 synchronous RAM (identical timing) and ignore data_out.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- flagLEDs  output  5  PSR as {Z, C, F, L, N}.
- r1  output  16  continuous copy of register r1.
- write_en  output  1  memory write strobe.
- addr  output  10  memory word address.
- data_out  input  16  memory read data, registered one cycle after addr.
- data_in  output  16  memory write data.

Behaviour:
- Reset (reset low, async):
  - all 16 registers, PC, PSR and IR are cleared to 0.
  - State = FETCH; write_en=0, addr=0, data_in=0.
  - Execution starts at address 0 on the first clk edge after release.
- Memory model: synchronous read. Data for addr presented in cycle n is valid on data_out in cycle n+1. A write occurs at the edge where write_en=1.
- FSM, 3 cycles per normal instruction:
  - FETCH: addr=PC[9:0].
  - DECODE: IR<=data_out.
  - EXECUTE: ALU operation and writeback, PSR update, PC update. PC<=PC+1 unless a branch/jump is taken. Next state FETCH.
- LOAD/STOR take 4 cycles: FETCH, DECODE, MEM, WB.
  - LOAD: MEM drives addr=Raddr[9:0]; WB writes Rdest<=data_out.
  - STOR: MEM drives addr=Raddr[9:0], data_in=Rsrc, write_en=1 for exactly one cycle; WB is idle.
  - Both: PC+1 in WB.
- Encoding: op[15:12], Rdest[11:8], ext[7:4], Rsrc[3:0]; imm8=[7:0].
- R-type (op 0000) by ext; matching immediate forms use op=ext code with imm8:
  - 0101 ADD: C=unsigned carry, F=signed overflow.
  - 0110 ADDU: sets C only.
  - 0111 ADDC: adds C in; C and F updated.
  - 1001 SUB: C=borrow, F=overflow.
  - 1011 CMP: no writeback.
  - 0001 AND, 0010 OR, 0011 XOR, 1101 MOV: no flags.
  - Immediates: ADDI/SUBI/CMPI sign-extend imm8; ANDI/ORI/XORI/MOVI zero-extend imm8.
  - op 1111 LUI: Rdest <= {imm8, Rdest[7:0]}.
- CMP/CMPI compute Rdest vs Rsrc/imm:
  - Z = equal.
  - L = Rdest < src, unsigned.
  - N = Rdest < src, signed.
  - C and F unchanged.
- Shifts (op 1000):
  - ext 0100 LSH: Rsrc is a signed amount; positive shifts left, negative shifts right logical.
  - ext 0000 LSHI: left by imm[3:0].
  - ext 0001 LSHI: right logical by imm[3:0].
  - Shifts do not affect flags.
- op 0100 memory and jumps:
  - ext 0000 LOAD Rdest, Raddr=[3:0].
  - ext 0100 STOR: Rsrc=[11:8], Raddr=[3:0].
  - ext 1000 JAL: Rlink=[11:8] <= PC+1; PC <= Rtarget.
  - ext 1100 Jcond: cond=[11:8]; if true, PC <= Rtarget=[3:0].
- op 1100 Bcond: cond=[11:8]; if true, PC <= PC + sext(imm8).
- Condition codes:
  - EQ 0000 = Z; NE 0001 = !Z.
  - CS 0010 = C; CC 0011 = !C.
  - HI 0100 = L; LS 0101 = !L.
  - GT 0110 = N; LE 0111 = !N.
  - FS 1000 = F; FC 1001 = !F.
  - LO 1010 = !L&!Z; HS 1011 = L|Z.
  - LT 1100 = !N&!Z; GE 1101 = N|Z.
  - UC 1110 = always; 1111 = never.
- Arithmetic is 16-bit wraparound. The PC is 16 bits; addr uses PC[9:0], so 1023+1 addresses 0.
- Undefined opcodes execute as NOP in 3 cycles.
- When Rdest and Rsrc are the same register, the source is read before writeback.
- A reset asserted mid-instruction aborts it. Any write_en in progress deasserts immediately.

Test Plan:
- Reset → r1=0, flagLEDs=00000, write_en=0, first fetch from address 0.
- MOVI r1,0 then loop of 11 Fibonacci steps via ADD/MOV → r1=233.
- CMP r2,r2 with r2=5 → flagLEDs=10000. Then CMPI (r2=5, imm=3) → 00000. LSHI r1=1 left 3 → r1=8. CMPI (r2=1, imm=5) → 00011. LSH r1=8 by r3=-2 → r1=2.
- MOVI r4,0x40; MOVI r5,100; STOR r5,r4; MOVI r1,0; LOAD r1,r4 → r1=100. write_en high exactly one cycle with addr=0x040 and data_in=100.
- Jump program: JAL over code, then Jcond UC and a never-taken Bcond → r1=60. Skipped instructions leave r1 unchanged.
- Bcond NE countdown loop computing Fibonacci to 987 → r1=987. Each taken branch costs 3 cycles and the loop terminates exactly when Z=1.
